// File: rtl/adc_capture_pkg.sv
// Shared types and default sizing for the ADC capture block.
package adc_capture_pkg;

  localparam int DEPTH_DEF  = 256;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W     = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/adc_capture_ram.sv
// Sample buffer: one write port, one registered read port (read-before-write).
module adc_capture_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge hclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) rdata <= '0;
    else          rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture.sv
// ADC conversion clock generator, arm/trigger/capture sequencer and sample buffer.
// Level trigger is compiled in only when ADC_CAPTURE_TRIG_EN is defined.
//
// state      | meaning
// ST_IDLE    | waiting for cfg_start, buffer holds last capture
// ST_ARM     | waiting for trigger (or first strobe when trigger not built)
// ST_CAPTURE | storing one sample per strobe until cfg_len+1 stored
// ST_DONE    | capture complete, done held high
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  input  logic [DATA_W-1:0]          adc_data,
  output logic                       adc_clk,
  input  logic [7:0]                 cfg_div,
  input  logic [$clog2(DEPTH)-1:0]   cfg_len,
  input  logic [DATA_W-1:0]          cfg_trig_level,
  input  logic                       cfg_trig_rising,
  input  logic                       cfg_start,
  input  logic                       cfg_abort,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     wr_count,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int AW = $clog2(DEPTH);

  state_e        state;
  logic [7:0]    div_cnt;
  logic          div_tc;
  logic          strobe;
  logic          fire;
  logic          full;
  logic          ram_we;
  logic [AW-1:0] len_q;
  logic [AW-1:0] ram_waddr;

  // cfg_div is only reloaded at terminal count, so a change never shortens a half-period
  assign div_tc = (div_cnt == 8'd0);
  assign strobe = div_tc && adc_clk;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      div_cnt <= 8'd0;
      adc_clk <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= cfg_div;
      adc_clk <= ~adc_clk;
    end else begin
      div_cnt <= div_cnt - 8'd1;
    end
  end

`ifdef ADC_CAPTURE_TRIG_EN
  logic [DATA_W-1:0] level_q;
  logic [DATA_W-1:0] prev_q;
  logic              rising_q;
  logic              first_q;
  logic              hit_rise;
  logic              hit_fall;

  assign hit_rise = (prev_q <  level_q) && (adc_data >= level_q);
  assign hit_fall = (prev_q >= level_q) && (adc_data <  level_q);
  // the first strobe after arming only seeds prev_q
  assign fire     = !first_q && (rising_q ? hit_rise : hit_fall);
`else
  logic unused_trig_cfg;
  assign unused_trig_cfg = ^{cfg_trig_level, cfg_trig_rising};
  assign fire            = 1'b1;
`endif

  assign full      = (wr_count == ((AW+1)'(len_q) + (AW+1)'(1)));
  assign ram_we    = strobe && !cfg_abort &&
                     (((state == ST_ARM) && fire) || ((state == ST_CAPTURE) && !full));
  assign ram_waddr = (state == ST_CAPTURE) ? wr_count[AW-1:0] : '0;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
      len_q    <= '0;
`ifdef ADC_CAPTURE_TRIG_EN
      level_q  <= '0;
      prev_q   <= '0;
      rising_q <= 1'b0;
      first_q  <= 1'b0;
`endif
    end else if (cfg_abort) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (cfg_start) begin
            state    <= ST_ARM;
            busy     <= 1'b1;
            done     <= 1'b0;
            wr_count <= '0;
            len_q    <= cfg_len;
`ifdef ADC_CAPTURE_TRIG_EN
            level_q  <= cfg_trig_level;
            rising_q <= cfg_trig_rising;
            first_q  <= 1'b1;
`endif
          end
        end
        ST_ARM: begin
          if (strobe) begin
`ifdef ADC_CAPTURE_TRIG_EN
            prev_q  <= adc_data;
            first_q <= 1'b0;
`endif
            if (fire) begin
              wr_count <= (AW+1)'(1);
              state    <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (full) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (strobe) begin
            wr_count <= wr_count + (AW+1)'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  adc_capture_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .hclk    (hclk),
    .hresetn (hresetn),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (adc_data),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_adc_capture.sv
// Directed self-checking bench for adc_capture (default 256 x 8 build).
module tb_adc_capture;

  logic       hclk = 1'b0;
  logic       hresetn = 1'b1;
  logic [7:0] adc_data;
  logic       adc_clk;
  logic [7:0] cfg_div = 8'd0;
  logic [7:0] cfg_len = 8'd0;
  logic [7:0] cfg_trig_level = 8'd0;
  logic       cfg_trig_rising = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_abort = 1'b0;
  logic       busy;
  logic       done;
  logic [8:0] wr_count;
  logic [7:0] rd_addr = 8'd0;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  // ADC model: a table of samples, advanced on every falling adc_clk
  logic [7:0] tab [512];
  int         sidx = 0;
  int         base = 0;
  logic [8:0] tab_idx;
  assign tab_idx  = 9'(sidx - base);
  assign adc_data = tab[tab_idx];

  always @(negedge adc_clk) begin
    #1;
    sidx = sidx + 1;
  end

  always #5 hclk = ~hclk;

  adc_capture dut (
    .hclk            (hclk),
    .hresetn         (hresetn),
    .adc_data        (adc_data),
    .adc_clk         (adc_clk),
    .cfg_div         (cfg_div),
    .cfg_len         (cfg_len),
    .cfg_trig_level  (cfg_trig_level),
    .cfg_trig_rising (cfg_trig_rising),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .busy            (busy),
    .done            (done),
    .wr_count        (wr_count),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    rd_addr = 8'(a);
    @(negedge hclk);
    d = rd_data;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge hclk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_wr(input string tag, input int val, input int budget);
    int n = 0;
    while (wr_count !== 9'(val) && n < budget) begin
      @(negedge hclk);
      n++;
    end
    check(tag, 32'(wr_count), 32'(val));
  endtask

  // Align to a falling adc_clk so the first strobe after start sees tab[0]
  task automatic start_capture(input int len);
    @(negedge adc_clk);
    #2;
    base    = sidx;
    cfg_len = 8'(len);
    @(negedge hclk);
    cfg_start = 1'b1;
    @(negedge hclk);
    cfg_start = 1'b0;
  endtask

  task automatic measure(input int win, output int period, output int high);
    int   r1 = -1;
    int   f1 = -1;
    int   r2 = -1;
    logic p;
    p = adc_clk;
    for (int i = 0; i < win; i++) begin
      @(negedge hclk);
      if (!p && adc_clk) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      if (p && !adc_clk && r1 >= 0 && f1 < 0) f1 = i;
      p = adc_clk;
    end
    period = r2 - r1;
    high   = f1 - r1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         per;
    int         hi;
    logic [7:0] d;

    for (int i = 0; i < 512; i++) tab[i] = 8'(i);

    #1 hresetn = 1'b0;
    #20;
    check("rst_adc_clk",  32'(adc_clk),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    @(negedge hclk);
    hresetn = 1'b1;

    // adc_clk period and duty
    cfg_div = 8'd0;
    repeat (4) @(negedge hclk);
    measure(12, per, hi);
    check("div0_period", 32'(per), 32'd2);
    check("div0_high",   32'(hi),  32'd1);
    cfg_div = 8'd4;
    repeat (12) @(negedge hclk);
    measure(40, per, hi);
    check("div4_period", 32'(per), 32'd10);
    check("div4_high",   32'(hi),  32'd5);
    cfg_div = 8'd0;
    repeat (12) @(negedge hclk);

`ifndef ADC_CAPTURE_TRIG_EN
    // short capture, first strobe after start lands at address 0
    for (int i = 0; i < 512; i++) tab[i] = 8'(16 + i);
    start_capture(7);
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_wr0",  32'(wr_count), 32'd0);
    wait_done("cap8_done", 200);
    check("cap8_wr",   32'(wr_count), 32'd8);
    check("cap8_busy", 32'(busy), 32'd0);
    rd(0, d); check("cap8_buf0", 32'(d), 32'h10);
    rd(7, d); check("cap8_buf7", 32'(d), 32'h17);
    repeat (10) @(negedge hclk);
    check("cap8_done_hold", 32'(done), 32'd1);

    // full-depth capture restarted from DONE
    for (int i = 0; i < 512; i++) tab[i] = 8'(i) ^ ((i >= 256) ? 8'hAA : 8'h2A);
    start_capture(255);
    check("restart_wr_clr", 32'(wr_count), 32'd0);
    check("restart_done0",  32'(done), 32'd0);
    wait_done("full_done", 2000);
    check("full_wr", 32'(wr_count), 32'd256);
    rd(255, d); check("full_buf255", 32'(d), 32'hD5);
    repeat (20) @(negedge hclk);
    check("full_wr_hold", 32'(wr_count), 32'd256);
    rd(0, d); check("full_buf0_nowrap", 32'(d), 32'h2A);

    // start ignored mid-capture, then abort with start at wr_count=10
    cfg_div = 8'd3;
    repeat (10) @(negedge hclk);
    for (int i = 0; i < 512; i++) tab[i] = 8'(8'h40 + i);
    start_capture(31);
    wait_wr("ab_reach5", 5, 200);
    cfg_start = 1'b1;
    @(negedge hclk);
    cfg_start = 1'b0;
    check("ign_start_wr",   32'(wr_count), 32'd5);
    check("ign_start_busy", 32'(busy), 32'd1);
    wait_wr("ab_reach10", 10, 200);
    cfg_abort = 1'b1;
    cfg_start = 1'b1;
    @(negedge hclk);
    cfg_abort = 1'b0;
    cfg_start = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wr",   32'(wr_count), 32'd10);
    repeat (40) @(negedge hclk);
    check("abort_wr_hold", 32'(wr_count), 32'd10);
    rd(9, d); check("abort_buf9", 32'(d), 32'h49);
    rd(0, d); check("abort_buf0", 32'(d), 32'h40);

    // reset mid-capture, then a fresh complete capture
    cfg_div = 8'd0;
    repeat (10) @(negedge hclk);
    for (int i = 0; i < 512; i++) tab[i] = 8'(8'hC0 + i);
    start_capture(15);
    wait_wr("rst_reach4", 4, 100);
    hresetn = 1'b0;
    #1;
    check("mid_rst_busy",    32'(busy), 32'd0);
    check("mid_rst_done",    32'(done), 32'd0);
    check("mid_rst_wr",      32'(wr_count), 32'd0);
    check("mid_rst_adc_clk", 32'(adc_clk), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    repeat (3) @(negedge hclk);
    hresetn = 1'b1;
    start_capture(15);
    wait_done("post_rst_done", 200);
    check("post_rst_wr", 32'(wr_count), 32'd16);
    rd(15, d); check("post_rst_buf15", 32'(d), 32'hCF);
    rd(0, d);  check("post_rst_buf0",  32'(d), 32'hC0);
`else
    // rising trigger on a ramp through 0x80
    for (int i = 0; i < 512; i++) tab[i] = 8'(8'h70 + 8 * i);
    cfg_trig_level  = 8'h80;
    cfg_trig_rising = 1'b1;
    start_capture(3);
    check("rise_busy", 32'(busy), 32'd1);
    wait_done("rise_done", 200);
    check("rise_wr", 32'(wr_count), 32'd4);
    rd(0, d); check("rise_buf0", 32'(d), 32'h80);
    rd(3, d); check("rise_buf3", 32'(d), 32'h98);

    // falling trigger: first sample below level must not trigger
    for (int i = 0; i < 512; i++) tab[i] = 8'h10;
    tab[0] = 8'h30;
    tab[1] = 8'h50;
    tab[2] = 8'h3F;
    tab[3] = 8'h20;
    cfg_trig_level  = 8'h40;
    cfg_trig_rising = 1'b0;
    start_capture(1);
    wait_done("fall_done", 200);
    check("fall_wr", 32'(wr_count), 32'd2);
    rd(0, d); check("fall_buf0", 32'(d), 32'h3F);
    rd(1, d); check("fall_buf1", 32'(d), 32'h20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
